// File: rtl/recebe_medidas_uc_pkg.sv
// Shared constants, frame-shape defaults and state encoding for the measurement receiver.
// Frame shape must stay identical to the transmitter side.
package recebe_medidas_uc_pkg;

  localparam logic [7:0] ZERO        = 8'h30;
  localparam logic [7:0] NOVE        = 8'h39;
  localparam logic [7:0] TERM_PADRAO = 8'h23;

  localparam int unsigned N_SENS_PADRAO = 3;
  localparam int unsigned N_DIG_PADRAO  = 3;

  // Enumerator values double as the db_estado debug code.
  typedef enum logic [2:0] {
    StInicial    = 3'b000,
    StEspera     = 3'b001,
    StCheca      = 3'b010,
    StProxSensor = 3'b011,
    StFim        = 3'b100,
    StFalha      = 3'b101
  } estado_e;

  localparam logic [2:0] ESTADO_INVALIDO = 3'b111;

  function automatic logic eh_digito(input logic [7:0] b);
    return (b >= ZERO) && (b <= NOVE);
  endfunction

endpackage

// File: rtl/recebe_medidas_uc_if.sv
// Host/UART-side signal bundle of the measurement receiver.
// master = host logic and UART receiver, slave = recebe_medidas_uc.
interface recebe_medidas_uc_if
  import recebe_medidas_uc_pkg::*;
#(
  parameter int unsigned BcdW = 4 * N_DIG_PADRAO
);

  logic            habilita;
  logic [7:0]      dado_rx;
  logic            pronto_rx;
  logic [BcdW-1:0] medida1;
  logic [BcdW-1:0] medida2;
  logic [BcdW-1:0] medida3;
  logic            pronto;
  logic            erro;
  logic [2:0]      db_estado;

  modport master (
    output habilita, dado_rx, pronto_rx,
    input  medida1, medida2, medida3, pronto, erro, db_estado
  );

  modport slave (
    input  habilita, dado_rx, pronto_rx,
    output medida1, medida2, medida3, pronto, erro, db_estado
  );

endinterface

// File: rtl/recebe_medidas_uc_contador_timeout.sv
// Modulo-TIMEOUT idle counter; fim flags the last count before wrap.
// zera has priority over conta.
module recebe_medidas_uc_contador_timeout #(
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int unsigned CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] Ultimo = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign fim = (cnt_q == Ultimo);

  always_comb begin
    cnt_d = cnt_q;
    if (zera) begin
      cnt_d = '0;
    end else if (conta) begin
      cnt_d = fim ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/recebe_medidas_uc.sv
// Receive-side frame assembler: validates "ddd#ddd#ddd#" bytes from the UART,
// commits each packet as BCD and reports frame completion or a sticky error.
module recebe_medidas_uc
  import recebe_medidas_uc_pkg::*;
#(
  parameter int unsigned N_SENS  = N_SENS_PADRAO,
  parameter int unsigned N_DIG   = N_DIG_PADRAO,
  parameter logic [7:0]  TERM    = TERM_PADRAO,
  parameter int unsigned TIMEOUT = 50_000_000
) (
  input logic               clock,
  input logic               reset,
  recebe_medidas_uc_if.slave bus
);

  localparam int unsigned BcdW     = 4 * N_DIG;
  localparam int unsigned IdxDigW  = $clog2(N_DIG + 1);
  localparam int unsigned IdxSensW = (N_SENS > 1) ? $clog2(N_SENS) : 1;

  estado_e               state_q, state_d;
  logic [IdxDigW-1:0]    idx_dig_q, idx_dig_d;
  logic [IdxSensW-1:0]   idx_sens_q, idx_sens_d;
  logic [BcdW-1:0]       shadow_q, shadow_d;
  logic [7:0]            byte_q, byte_d;
  logic [BcdW-1:0]       medida_q [N_SENS];
  logic [BcdW-1:0]       medida_d [N_SENS];
  logic                  erro_q, erro_d;
  logic                  zera, conta, fim_timeout;
  logic                  pronto;
  logic [2:0]            db_estado;

  recebe_medidas_uc_contador_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (conta),
    .fim   (fim_timeout)
  );

  always_comb begin
    state_d    = state_q;
    idx_dig_d  = idx_dig_q;
    idx_sens_d = idx_sens_q;
    shadow_d   = shadow_q;
    byte_d     = byte_q;
    medida_d   = medida_q;
    erro_d     = erro_q;
    zera       = 1'b0;
    conta      = 1'b0;
    pronto     = 1'b0;

    case (state_q)
      StInicial: begin
        if (bus.habilita) begin
          erro_d     = 1'b0;
          idx_dig_d  = '0;
          idx_sens_d = '0;
          zera       = 1'b1;
          state_d    = StEspera;
        end
      end

      StEspera: begin
        conta = 1'b1;
        // A strobe in the same cycle as the timeout still wins.
        if (bus.pronto_rx) begin
          byte_d  = bus.dado_rx;
          zera    = 1'b1;
          state_d = StCheca;
        end else if (fim_timeout) begin
          state_d = StFalha;
        end
      end

      StCheca: begin
        if (idx_dig_q < IdxDigW'(N_DIG)) begin
          if (eh_digito(byte_q)) begin
            // MSD arrives first, so older digits move up one nibble.
            shadow_d  = (shadow_q << 4) | BcdW'(byte_q[3:0]);
            idx_dig_d = idx_dig_q + IdxDigW'(1);
            state_d   = StEspera;
          end else begin
            state_d = StFalha;
          end
        end else if (byte_q == TERM) begin
          medida_d[idx_sens_q] = shadow_q;
          shadow_d             = '0;
          idx_dig_d            = '0;
          state_d = (idx_sens_q == IdxSensW'(N_SENS - 1)) ? StFim : StProxSensor;
        end else begin
          state_d = StFalha;
        end
      end

      StProxSensor: begin
        idx_sens_d = idx_sens_q + IdxSensW'(1);
        state_d    = StEspera;
      end

      StFim: begin
        pronto  = 1'b1;
        state_d = StInicial;
      end

      StFalha: begin
        erro_d  = 1'b1;
        state_d = StInicial;
      end

      default: begin
        state_d = StInicial;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StInicial;
      idx_dig_q  <= '0;
      idx_sens_q <= '0;
      shadow_q   <= '0;
      byte_q     <= '0;
      erro_q     <= 1'b0;
      for (int i = 0; i < N_SENS; i++) begin
        medida_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_dig_q  <= idx_dig_d;
      idx_sens_q <= idx_sens_d;
      shadow_q   <= shadow_d;
      byte_q     <= byte_d;
      erro_q     <= erro_d;
      medida_q   <= medida_d;
    end
  end

  always_comb begin
    case (state_q)
      StInicial, StEspera, StCheca, StProxSensor, StFim, StFalha: db_estado = state_q;
      default:                                                    db_estado = ESTADO_INVALIDO;
    endcase
  end

  assign bus.medida1   = medida_q[0];
  assign bus.medida2   = medida_q[1];
  assign bus.medida3   = medida_q[2];
  assign bus.pronto    = pronto;
  assign bus.erro      = erro_q;
  assign bus.db_estado = db_estado;

endmodule

// File: tb/tb_recebe_medidas_uc.sv
// Bench for recebe_medidas_uc: directed frames plus random frames against a cycle-timed
// frame model; one negedge process compares every output every cycle.
module tb_recebe_medidas_uc;

  localparam int TimeoutTb = 100;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  recebe_medidas_uc_if bus ();

  recebe_medidas_uc #(
    .TIMEOUT (TimeoutTb)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Model: each output is "old value until at, new value from at".
  logic [11:0] med_old [3];
  logic [11:0] med_new [3];
  int          med_at  [3];
  logic        erro_old, erro_new;
  int          erro_at;
  int          pronto_at;
  // Frame progress as seen from the byte stream.
  bit          m_active, m_waiting;
  int          m_ws, m_idle, m_pkt, m_ndig;
  logic [11:0] m_val;

  int  t_last;
  int  pin_req = 0, pin_t0 = 0, pin_t1 = 0;
  bit  chk_en = 1'b0;

  // Owned by the compare process.
  int   n_cmp = 0, n_bad = 0;
  int   pin_done = 0;
  int   pronto_seen = -1, erro_rise = -1;
  logic erro_prev = 1'b0;

  function automatic logic [11:0] exp_med(input int i);
    return (cyc >= med_at[i]) ? med_new[i] : med_old[i];
  endfunction

  function automatic logic exp_erro();
    return (cyc >= erro_at) ? erro_new : erro_old;
  endfunction

  function automatic logic [11:0] med_dut(input int i);
    case (i)
      0:       return bus.medida1;
      1:       return bus.medida2;
      default: return bus.medida3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("medida%0d", i + 1), 32'(med_dut(i)), 32'(exp_med(i)));
      end
      chk("pronto", 32'(bus.pronto), 32'(cyc == pronto_at));
      chk("erro", 32'(bus.erro), 32'(exp_erro()));
      if (!m_active && cyc >= m_idle) begin
        chk("db_estado_inicial", 32'(bus.db_estado), 32'd0);
      end else if (m_active && m_waiting && cyc >= m_ws) begin
        chk("db_estado_espera", 32'(bus.db_estado), 32'd1);
      end
      if (bus.pronto === 1'b1) pronto_seen = cyc;
      if (bus.erro === 1'b1 && erro_prev !== 1'b1) erro_rise = cyc;
      erro_prev = bus.erro;

      if (pin_req != pin_done) begin
        case (pin_req)
          1: begin
            chk("pin1_medida1", 32'(bus.medida1), 32'h123);
            chk("pin1_medida2", 32'(bus.medida2), 32'h045);
            chk("pin1_medida3", 32'(bus.medida3), 32'h999);
            chk("pin1_erro", 32'(bus.erro), 32'd0);
            chk("pin1_pronto_cycle", pronto_seen, pin_t0);
          end
          2: begin
            chk("pin2_erro", 32'(bus.erro), 32'd1);
            chk("pin2_medida1", 32'(bus.medida1), 32'h123);
            chk("pin2_medida3", 32'(bus.medida3), 32'h999);
            chk("pin2_erro_cycle", erro_rise, pin_t0);
            chk("pin2_no_pronto", pronto_seen, pin_t1);
          end
          3: begin
            chk("pin3_medida1", 32'(bus.medida1), 32'h321);
            chk("pin3_medida2", 32'(bus.medida2), 32'h045);
            chk("pin3_erro", 32'(bus.erro), 32'd1);
          end
          4: chk("pin4_erro_cleared", 32'(bus.erro), 32'd0);
          5: begin
            chk("pin5_timeout_erro", 32'(bus.erro), 32'd1);
            chk("pin5_timeout_cycle", erro_rise, pin_t0);
          end
          6: begin
            chk("pin6_medida1", 32'(bus.medida1), 32'h007);
            chk("pin6_medida2", 32'(bus.medida2), 32'h008);
            chk("pin6_medida3", 32'(bus.medida3), 32'h009);
            chk("pin6_erro", 32'(bus.erro), 32'd0);
          end
          7: begin
            chk("pin7_db_estado", 32'(bus.db_estado), 32'd0);
            chk("pin7_medida2", 32'(bus.medida2), 32'h008);
            chk("pin7_no_pronto", pronto_seen, pin_t0);
          end
          default: ;
        endcase
        pin_done = pin_req;
      end
    end
  end

  task automatic sched_med(input int i, input logic [11:0] v, input int t);
    med_old[i] = exp_med(i);
    med_new[i] = v;
    med_at[i]  = t;
  endtask

  task automatic sched_erro(input logic v, input int t);
    erro_old = exp_erro();
    erro_new = v;
    erro_at  = t;
  endtask

  task automatic fail_frame(input int n);
    sched_erro(1'b1, n + 3);
    m_active = 1'b0;
    m_idle   = n + 3;
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (m_active && m_waiting && cyc == m_ws + TimeoutTb) begin
      m_active  = 1'b0;
      m_waiting = 1'b0;
      sched_erro(1'b1, cyc + 1);
      m_idle = cyc + 1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int n = cyc;
    if (m_active && m_waiting) begin
      m_waiting = 1'b0;
      if (m_ndig < 3) begin
        if (b >= 8'h30 && b <= 8'h39) begin
          m_val     = 12'((m_val * 16) + (b - 8'h30));
          m_ndig++;
          m_ws      = n + 2;
          m_waiting = 1'b1;
        end else begin
          fail_frame(n);
        end
      end else if (b == 8'h23) begin
        sched_med(m_pkt, m_val, n + 2);
        m_val  = '0;
        m_ndig = 0;
        if (m_pkt == 2) begin
          pronto_at = n + 2;
          m_active  = 1'b0;
          m_idle    = n + 3;
        end else begin
          m_pkt++;
          m_ws      = n + 3;
          m_waiting = 1'b1;
        end
      end else begin
        fail_frame(n);
      end
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    bus.dado_rx   = b;
    bus.pronto_rx = 1'b1;
    t_last        = cyc;
    model_byte(b);
    step();
    bus.pronto_rx = 1'b0;
    bus.dado_rx   = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) step();
    while (m_active && m_waiting && cyc < m_ws) step();
    strobe(b);
  endtask

  task automatic send_str(input string s, input int gap_max);
    for (int i = 0; i < s.len(); i++) send(s[i], int'($urandom_range(gap_max, 0)));
  endtask

  task automatic wait_idle();
    while (m_active || cyc < m_idle) step();
  endtask

  task automatic start_frame();
    wait_idle();
    bus.habilita = 1'b1;
    m_active  = 1'b1;
    m_waiting = 1'b1;
    m_ws      = cyc + 1;
    m_pkt     = 0;
    m_ndig    = 0;
    m_val     = '0;
    sched_erro(1'b0, cyc + 1);
    step();
    bus.habilita = 1'b0;
  endtask

  task automatic do_reset();
    while (!((m_active && m_waiting && cyc >= m_ws) || (!m_active && cyc >= m_idle))) step();
    reset     = 1'b1;
    m_active  = 1'b0;
    m_waiting = 1'b0;
    m_idle    = cyc + 1;
    for (int i = 0; i < 3; i++) sched_med(i, 12'h000, cyc + 1);
    sched_erro(1'b0, cyc + 1);
    pronto_at = -1;
    step();
    reset = 1'b0;
  endtask

  task automatic pin(input int k);
    pin_req = k;
    for (int i = 0; i < 4 && pin_done != k; i++) step();
  endtask

  initial begin
    bus.habilita  = 1'b0;
    bus.pronto_rx = 1'b0;
    bus.dado_rx   = 8'h00;
    reset         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      med_old[i] = '0;
      med_new[i] = '0;
      med_at[i]  = 0;
    end
    erro_old  = 1'b0;
    erro_new  = 1'b0;
    erro_at   = 0;
    pronto_at = -1;
    m_active  = 1'b0;
    m_waiting = 1'b0;
    m_ws      = 0;
    m_idle    = 0;
    m_pkt     = 0;
    m_ndig    = 0;
    m_val     = '0;
    repeat (3) step();
    reset  = 1'b0;
    m_idle = cyc;
    chk_en = 1'b1;
    repeat (3) step();

    start_frame();
    send_str("123#045#999#", 3);
    pin_t0 = t_last + 2;
    pin_t1 = pin_t0;
    wait_idle();
    step();
    pin(1);

    start_frame();
    send_str("12A", 2);
    pin_t0 = t_last + 3;
    wait_idle();
    step();
    pin(2);
    send_str("#045#999#", 2);

    start_frame();
    send_str("321#654X", 2);
    wait_idle();
    step();
    pin(3);

    // habilita clears erro; then strobe on the last idle cycle, then go silent.
    start_frame();
    pin(4);
    while (cyc < m_ws + TimeoutTb - 1) step();
    strobe(8'h31);
    send(8'h32, 0);
    pin_t0 = m_ws + TimeoutTb + 1;
    wait_idle();
    step();
    pin(5);

    start_frame();
    send_str("123#4", 2);
    do_reset();
    repeat (2) step();
    start_frame();
    send_str("007#008#009#", 1);
    pin_t0 = t_last + 2;
    wait_idle();
    step();
    pin(6);

    send_str("555#", 2);
    step();
    pin(7);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(14, 0) == 0) do_reset();
      start_frame();
      for (int j = 0; j < 12; j++) begin
        logic [7:0] b;
        b = ((j % 4) == 3) ? 8'h23 : 8'(8'h30 + $urandom_range(9, 0));
        if ($urandom_range(99, 0) < 6) b = 8'($urandom);
        if ($urandom_range(39, 0) == 0) do_reset();
        send(b, int'($urandom_range(4, 0)));
      end
      wait_idle();
      if ($urandom_range(3, 0) == 0) send(8'(8'h30 + $urandom_range(9, 0)), 1);
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
